// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the wait-state data memory controller.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned WAIT_CNT_W = 4;

  // Byte address to word address; callers truncate to their SRAM index width.
  function automatic logic [29:0] word_index(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/data_mem_ctrl_wait_timer.sv
// Loadable down-counter with a zero flag; paces the wait states before the SRAM strobe.
module wait_timer
  import data_mem_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WAIT_CNT_W-1:0] load_val,
  input  logic                  dec,
  output logic                  zero
);

  logic [WAIT_CNT_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/data_mem_ctrl.sv
// Wait-state data memory controller between the core load/store path and a single-port SRAM.
// Optional misalignment trap compiled in with MISALIGN_TRAP_EN.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic                     req_write,
  input  logic [31:0]              req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     stall,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                     err_misaligned
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_t            state, state_nx;
  logic              wr_q;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] hold_q;
  logic              timer_load, timer_dec, timer_zero;
  logic              access_ok;
  logic              accept;

  assign accept = (state == IDLE) && req_valid;

  wait_timer u_wait_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timer_load),
    .load_val (WAIT_CNT_W'(WAIT_STATES)),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

`ifdef MISALIGN_TRAP_EN
  logic mis_q;
  logic err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (accept)
        mis_q <= (req_addr[1:0] != 2'b00);
      if ((state == RESP) && mis_q)
        err_q <= 1'b1;
    end
  end

  assign access_ok      = !mis_q;
  assign err_misaligned = err_q;
`else
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^req_addr[1:0];
  assign access_ok        = 1'b1;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
    end else begin
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= AW'(word_index(req_addr));
        wdata_q <= req_wdata;
      end
      if ((state == RESP) && !wr_q && access_ok)
        hold_q <= mem_rdata;
    end
  end

  always_comb begin
    state_nx   = state;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    stall      = 1'b0;
    rsp_valid  = 1'b0;
    mem_en     = 1'b0;
    rsp_rdata  = hold_q;
    case (state)
      IDLE: begin
        if (req_valid) begin
          stall      = 1'b1;
          timer_load = 1'b1;
          state_nx   = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (timer_zero) begin
          mem_en   = access_ok;
          state_nx = RESP;
        end else begin
          timer_dec = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (!access_ok)
          rsp_rdata = '0;
        else if (!wr_q)
          rsp_rdata = mem_rdata;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // IDLE stall follows req_valid combinationally, so it must be masked while reset is held.
    if (reset)
      stall = 1'b0;
  end

  assign mem_we    = mem_en && wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
